// File: rtl/de_pkg.sv
// Shared definitions for the scripted decode stage: decoded micro-op bundle
// layout, playback state encoding and the all-zero bubble.
package de_pkg;

  localparam int UOP_W = 210;

  // Bundle fields listed LSB upward; the MSB is re.
  localparam int RM_OFF      = 0;
  localparam int RO_OFF      = 1;
  localparam int JMP_OFF     = 2;
  localparam int JMP_W       = 3;
  localparam int MODRM_OFF   = 5;
  localparam int MODRM_W     = 8;
  localparam int PTR_OFF     = 13;
  localparam int PTR_W       = 16;
  localparam int SREG_OFF    = 29;
  localparam int SREG_W      = 16;
  localparam int FLAG_LD_OFF = 45;
  localparam int FLAGS_OFF   = 77;
  localparam int DISP_OFF    = 109;
  localparam int SVAL_OFF    = 141;
  localparam int DVAL_OFF    = 173;
  localparam int WORD_W      = 32;
  localparam int ALUSEL_OFF  = 205;
  localparam int ALUSEL_W    = 2;
  localparam int RMSEL_OFF   = 207;
  localparam int WE_OFF      = 208;
  localparam int RE_OFF      = 209;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [UOP_W-1:0] UOP_BUBBLE = '0;

endpackage

// File: rtl/de_uop_table.sv
// Micro-op program table: one synchronous write port, one asynchronous read
// port, no reset so contents survive a stage reset.
module de_uop_table
  import de_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [UOP_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [UOP_W-1:0] rdata
);

  logic [UOP_W-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/de_uop_player.sv
// Scripted decode stage: plays programmed micro-op bundles into AG under the
// ld_ag/ag_vin handshake, in one-shot or looping mode, counting accepts.
module de_uop_player
  import de_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LOOP  = 0,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_we,
  input  logic [IDX_W-1:0] prog_addr,
  input  logic [UOP_W-1:0] prog_uop,
  input  logic             start,
  input  logic [IDX_W:0]   length,
  input  logic             reg_dep,
  input  logic             mem_dep,
  input  logic             mr_stall,
  input  logic             mw_stall,
  output logic             de_v,
  output logic             ld_ag,
  output logic             ag_vin,
  output logic             de_re,
  output logic             de_we,
  output logic             de_rmsel,
  output logic             ro_needed,
  output logic             rm_needed,
  output logic [1:0]       de_alusel,
  output logic [2:0]       de_jmp,
  output logic [7:0]       de_modrm,
  output logic [15:0]      de_sreg,
  output logic [15:0]      de_ptr,
  output logic [31:0]      de_dval,
  output logic [31:0]      de_sval,
  output logic [31:0]      de_disp,
  output logic [31:0]      de_flags,
  output logic [31:0]      de_flag_ld,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

  state_t           state_r, state_n;
  logic [IDX_W-1:0] ptr_r, ptr_n;
  logic [IDX_W:0]   len_r, len_n;
  logic [UOP_W-1:0] uop_r, uop_n;
  logic             de_v_r, de_v_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;

  logic             tbl_we_s, accept_s, last_s;
  logic [IDX_W:0]   len_clamp_s;
  logic [IDX_W-1:0] rd_addr_s;
  logic [UOP_W-1:0] tbl_rd_s, rd_uop_s;

  assign tbl_we_s    = prog_we & (state_r != ST_PLAY);
  assign ld_ag       = ~(mem_dep | mr_stall | mw_stall);
  assign ag_vin      = de_v_r & ~reg_dep;
  assign accept_s    = ld_ag & ag_vin;
  assign len_clamp_s = (length > DEPTH_L) ? DEPTH_L : length;
  assign last_s      = ({1'b0, ptr_r} == (len_r - (IDX_W+1)'(1)));

  de_uop_table #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_table (
    .clk   (clk),
    .we    (tbl_we_s),
    .waddr (prog_addr),
    .wdata (prog_uop),
    .raddr (rd_addr_s),
    .rdata (tbl_rd_s)
  );

  // Index of the bundle loaded on the next accept or start
  always_comb begin
    rd_addr_s = '0;
    if ((state_r == ST_PLAY) && !last_s) begin
      rd_addr_s = ptr_r + IDX_W'(1);
    end else begin
      rd_addr_s = '0;
    end
  end

  // A same-cycle write forwards so start sees freshly written entry 0
  assign rd_uop_s = (tbl_we_s && (prog_addr == rd_addr_s)) ? prog_uop : tbl_rd_s;

  // Playback next-state and next output bundle
  always_comb begin
    state_n = state_r;
    ptr_n   = ptr_r;
    len_n   = len_r;
    uop_n   = uop_r;
    de_v_n  = de_v_r;
    cnt_n   = cnt_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          len_n = len_clamp_s;
          cnt_n = '0;
          ptr_n = '0;
          if (len_clamp_s != '0) begin
            state_n = ST_PLAY;
            uop_n   = rd_uop_s;
            de_v_n  = 1'b1;
          end else begin
            state_n = ST_DONE;
            uop_n   = UOP_BUBBLE;
            de_v_n  = 1'b0;
          end
        end else begin
          state_n = state_r;
        end
      end
      ST_PLAY: begin
        if (accept_s) begin
          cnt_n = cnt_r + CNT_W'(1);
          if (!last_s) begin
            ptr_n = ptr_r + IDX_W'(1);
            uop_n = rd_uop_s;
          end else if (LOOP != 0) begin
            ptr_n = '0;
            uop_n = rd_uop_s;
          end else begin
            state_n = ST_DONE;
            ptr_n   = '0;
            uop_n   = UOP_BUBBLE;
            de_v_n  = 1'b0;
          end
        end else begin
          state_n = state_r;
        end
      end
      default: begin
        state_n = ST_IDLE;
        ptr_n   = '0;
        uop_n   = UOP_BUBBLE;
        de_v_n  = 1'b0;
      end
    endcase
  end

  // Playback state and registered output bundle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      len_r   <= '0;
      uop_r   <= UOP_BUBBLE;
      de_v_r  <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      len_r   <= len_n;
      uop_r   <= uop_n;
      de_v_r  <= de_v_n;
      cnt_r   <= cnt_n;
    end
  end

  assign de_v       = de_v_r;
  assign busy       = (state_r == ST_PLAY);
  assign done       = (state_r == ST_DONE);
  assign issued_cnt = cnt_r;
  assign de_re      = uop_r[RE_OFF];
  assign de_we      = uop_r[WE_OFF];
  assign de_rmsel   = uop_r[RMSEL_OFF];
  assign ro_needed  = uop_r[RO_OFF];
  assign rm_needed  = uop_r[RM_OFF];
  assign de_alusel  = uop_r[ALUSEL_OFF +: ALUSEL_W];
  assign de_jmp     = uop_r[JMP_OFF +: JMP_W];
  assign de_modrm   = uop_r[MODRM_OFF +: MODRM_W];
  assign de_sreg    = uop_r[SREG_OFF +: SREG_W];
  assign de_ptr     = uop_r[PTR_OFF +: PTR_W];
  assign de_dval    = uop_r[DVAL_OFF +: WORD_W];
  assign de_sval    = uop_r[SVAL_OFF +: WORD_W];
  assign de_disp    = uop_r[DISP_OFF +: WORD_W];
  assign de_flags   = uop_r[FLAGS_OFF +: WORD_W];
  assign de_flag_ld = uop_r[FLAG_LD_OFF +: WORD_W];

endmodule

// File: doc/de_uop_player.md
# de_uop_player

Parametrised scripted decode stage that drives pre-programmed decoded micro-op bundles into the AG stage. It replaces the fixed two-entry decode stub with a programmable table of up to DEPTH bundles, a configurable play length, one-shot or loop mode, and an issue counter. It sits between fetch and AG. It obeys the same ld_ag/ag_vin stall handshake, so AG, RO and memory stages can be exercised with arbitrary instruction sequences.

## Interface
- DEPTH, 4: number of table entries (≥2); IDX_W = $clog2(DEPTH)
- LOOP, 0: 1 = wrap to entry 0 after the last entry; 0 = stop after the last entry
- CNT_W, 16: width of issued_cnt
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- prog_we  in  1  table write strobe; honoured only in IDLE/DONE
- prog_addr  in  IDX_W  table write index
- prog_uop  in  UOP_W  packed bundle (layout in de_pkg)
- start  in  1  begin playback from entry 0; ignored in PLAY
- length  in  IDX_W+1  entries to play; sampled at start; values >DEPTH clamp to DEPTH
- reg_dep, mem_dep, mr_stall, mw_stall  in  1 each  hazard/stall inputs
- de_v  out  1  current output bundle valid
- ld_ag  out  1  = !(mem_dep | mr_stall | mw_stall)
- ag_vin  out  1  = de_v & !reg_dep
- de_re, de_we, de_rmsel, ro_needed, rm_needed  out  1 each  bundle fields
- de_alusel  out  2; de_jmp  out  3; de_modrm  out  8; de_sreg, de_ptr  out  16 each
- de_dval, de_sval, de_disp, de_flags, de_flag_ld  out  32 each
- busy  out  1  state == PLAY
- done  out  1  state == DONE (sticky)
- issued_cnt  out  CNT_W  bundles accepted since last start

## Operation
- accept = ld_ag & ag_vin. A bundle is consumed only on accept; otherwise all outputs hold.
- States: IDLE, PLAY, DONE.
  - IDLE: bubble on outputs (de_v=0, all fields 0).
  - start with len>0 → PLAY: ptr←0; output regs ← table[0]; de_v←1; issued_cnt←0.
  - start with len=0 → DONE directly; issued_cnt←0.
  - PLAY, accept, ptr≠len−1 → ptr+1; load table[ptr+1].
  - PLAY, accept, ptr=len−1, LOOP=1 → ptr←0; load table[0]; stay in PLAY.
  - PLAY, accept, ptr=len−1, LOOP=0 → DONE; outputs ← bubble.
  - DONE: bubble; start behaves as from IDLE (replay).
- issued_cnt increments on every accept, wraps modulo 2^CNT_W, and is cleared only by start and rst.
- prog_we in PLAY is dropped (table unchanged). A write and start in the same cycle from IDLE/DONE: write lands first; a write to entry 0 is visible in the first bundle.
- Flag fields are passed through opaquely; no arithmetic is done on bundle contents.

## Timing
- rst (any time, including mid-play): state=IDLE, ptr=0, de_v=0, every field 0, busy=0, done=0, issued_cnt=0. Table contents are undefined after power-up and preserved across rst.
- start at edge t → de_v=1 with table[0] visible after edge t+1 (one-cycle latency).
- Continuous accept gives one bundle per cycle with no bubbles, including across the loop wrap.
- Last accept at edge k (LOOP=0) → de_v=0, done=1 after edge k+1.
- ld_ag and ag_vin are combinational from the inputs and the de_v register. There is no register between the stall inputs and the advance decision.
- reg_dep=1 with de_v=1: ag_vin=0; outputs hold and ptr holds.

## Structure
- de_pkg holds:
  - UOP_W (= 210)
  - field offset/width localparams, with packing order re, we, rmsel, alusel, dval, sval, disp, flags, flag_ld, sreg, ptr, modrm, jmp, ro_needed, rm_needed (MSB→LSB)
  - the state enum
  - UOP_BUBBLE (all zero)
- Sub-module de_uop_table: DEPTH×UOP_W, one synchronous write port, one asynchronous read port. It has no reset.

## Test plan
- Program entries 0..3 with distinct de_disp 1..4; length=4, LOOP=0; no stalls → de_disp 1,2,3,4 on consecutive cycles; then de_v=0, done=1, issued_cnt=4.
- Same program; mr_stall=1 for 3 cycles while entry 1 is shown → entry 1 holds 3 cycles; ld_ag=0; issued_cnt frozen; sequence then completes in order.
- reg_dep=1 on entry 2 → ag_vin=0 and outputs hold; release → entry 3 follows next cycle.
- LOOP=1, length=3, 7 accepts → de_disp 1,2,3,1,2,3,1; busy stays 1; issued_cnt=7.
- length=0 start → done=1 next cycle, de_v never 1. length=9 with DEPTH=4 → plays 4 entries.
- Assert rst during PLAY at entry 2 → all outputs 0 immediately. Then start → entry 0 replays with the table intact. prog_we during PLAY → table unchanged.
